// File: rtl/tlb_pkg.sv
// Shared TLB types: refill FSM state encoding, walker request/response records, counter helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: TLB_VPN_W / TLB_PTE_W default widths, state_e, ptw_req_t, ptw_resp_t, sat_inc().
package tlb_pkg;

   // Walker record widths; instances of the refill controller use these as their defaults.
   localparam int unsigned TLB_VPN_W = 27;
   localparam int unsigned TLB_PTE_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_FILL  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Walker request: the page being refilled.
   typedef struct packed {
      logic [TLB_VPN_W-1:0] vpn;
   } ptw_req_t;

   // Walker response: fault flag plus the page table entry.
   typedef struct packed {
      logic                 error;
      logic [TLB_PTE_W-1:0] pte;
   } ptw_resp_t;

   // Saturating 32-bit increment for event counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// Bundle of every handshake/data signal between the refill controller, TLB CAM, PLRU tree and walker.
// Latency: n/a (wires only).
// Backpressure: lookup uses valid/ready, walker request uses valid/ready, walker response is always accepted.
// Modports: master = refill controller, slave = surrounding TLB (CAM, PLRU, walker, entry array).
interface tlb_refill_ctrl_if
   import tlb_pkg::*;
#(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned VPN_W   = TLB_VPN_W,
   parameter int unsigned PTE_W   = TLB_PTE_W
) ();

   localparam int unsigned IW = $clog2(ENTRIES);

   // lookup from the CAM
   logic             lookup_valid_i;
   logic             lookup_ready_o;
   logic             lookup_hit_i;
   logic [IW-1:0]    lookup_hit_idx_i;
   logic [VPN_W-1:0] lookup_vpn_i;

   // walker request / response
   logic             ptw_req_valid_o;
   logic             ptw_req_ready_i;
   logic [VPN_W-1:0] ptw_req_vpn_o;
   logic             ptw_resp_valid_i;
   logic             ptw_resp_error_i;
   logic [PTE_W-1:0] ptw_resp_pte_i;

   // replacement tree
   logic             plru_access_hit_o;
   logic [IW-1:0]    plru_access_idx_o;
   logic [IW-1:0]    plru_replacement_idx_i;

   // entry write
   logic             fill_valid_o;
   logic [IW-1:0]    fill_idx_o;
   logic [VPN_W-1:0] fill_vpn_o;
   logic [PTE_W-1:0] fill_pte_o;

   // control / status
   logic             flush_i;
   logic             busy_o;
   logic             miss_error_o;

   modport master (
      input  lookup_valid_i, lookup_hit_i, lookup_hit_idx_i, lookup_vpn_i,
      output lookup_ready_o,
      output ptw_req_valid_o, ptw_req_vpn_o,
      input  ptw_req_ready_i,
      input  ptw_resp_valid_i, ptw_resp_error_i, ptw_resp_pte_i,
      output plru_access_hit_o, plru_access_idx_o,
      input  plru_replacement_idx_i,
      output fill_valid_o, fill_idx_o, fill_vpn_o, fill_pte_o,
      input  flush_i,
      output busy_o, miss_error_o
   );

   modport slave (
      output lookup_valid_i, lookup_hit_i, lookup_hit_idx_i, lookup_vpn_i,
      input  lookup_ready_o,
      input  ptw_req_valid_o, ptw_req_vpn_o,
      output ptw_req_ready_i,
      output ptw_resp_valid_i, ptw_resp_error_i, ptw_resp_pte_i,
      input  plru_access_hit_o, plru_access_idx_o,
      output plru_replacement_idx_i,
      input  fill_valid_o, fill_idx_o, fill_vpn_o, fill_pte_o,
      output flush_i,
      input  busy_o, miss_error_o
   );

endinterface

// File: rtl/tlb_refill_ctrl.sv
// TLB miss refill controller: reports hits to the PLRU tree, walks misses through the PTW and writes the victim entry.
// Latency: hit update same cycle; miss acceptance to fill_valid_o = 1 + req-handshake wait + resp wait + 1 (min 3 cycles).
// Backpressure: lookups accepted only in IDLE without flush; walker request held until ptw_req_ready_i; responses never stalled.
// Ports: clk_i, rstn_i (async active-low), bus (tlb_refill_ctrl_if.master: lookup, ptw req/resp, plru, fill, flush/busy/error).
// Optional: define TLB_REFILL_PERF_EN to add saturating 32-bit miss_count_o / hit_count_o.
// Walker record structs are sized by tlb_pkg widths; VPN_W / PTE_W are expected to match them.
module tlb_refill_ctrl
   import tlb_pkg::*;
#(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned VPN_W   = TLB_VPN_W,
   parameter int unsigned PTE_W   = TLB_PTE_W
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   tlb_refill_ctrl_if.master bus
`ifdef TLB_REFILL_PERF_EN
   ,
   output logic [31:0]       miss_count_o,
   output logic [31:0]       hit_count_o
`endif
);

   localparam int unsigned IW = $clog2(ENTRIES);

   state_e        state_q, state_d;
   ptw_req_t      req_q;        // page under refill; also drives the walker request
   logic [TLB_PTE_W-1:0] pte_q;
   logic [IW-1:0] victim_q;     // snapshot of the PLRU victim at miss time
   logic          miss_error_q;

   ptw_resp_t     resp;
   logic          lookup_acc;
   logic          hit_accept;
   logic          miss_accept;
   logic          resp_ok;
   logic          resp_err;

   assign resp = '{error: bus.ptw_resp_error_i, pte: TLB_PTE_W'(bus.ptw_resp_pte_i)};

   // A flush blocks lookup acceptance in the same cycle it is seen.
   assign lookup_acc  = (state_q == ST_IDLE) && !bus.flush_i && bus.lookup_valid_i;
   assign hit_accept  = lookup_acc &&  bus.lookup_hit_i;
   assign miss_accept = lookup_acc && !bus.lookup_hit_i;

   // Responses only count in WAIT without a concurrent flush; flush wins over a fault too.
   assign resp_ok  = (state_q == ST_WAIT) && !bus.flush_i && bus.ptw_resp_valid_i && !resp.error;
   assign resp_err = (state_q == ST_WAIT) && !bus.flush_i && bus.ptw_resp_valid_i &&  resp.error;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (miss_accept) state_d = ST_REQ;
         end
         ST_REQ: begin
            // Once the walker has taken the request its response is still owed, so a
            // flush in the handshake cycle must swallow it in DRAIN.
            if (bus.flush_i)              state_d = bus.ptw_req_ready_i ? ST_DRAIN : ST_IDLE;
            else if (bus.ptw_req_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.flush_i)               state_d = bus.ptw_resp_valid_i ? ST_IDLE : ST_DRAIN;
            else if (bus.ptw_resp_valid_i) state_d = resp.error ? ST_IDLE : ST_FILL;
         end
         ST_FILL: begin
            state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (bus.ptw_resp_valid_i) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      bus.lookup_ready_o    = (state_q == ST_IDLE) && !bus.flush_i;
      bus.busy_o            = (state_q != ST_IDLE);
      bus.ptw_req_valid_o   = (state_q == ST_REQ);
      bus.ptw_req_vpn_o     = VPN_W'(req_q.vpn);
      bus.fill_valid_o      = 1'b0;
      bus.fill_idx_o        = victim_q;
      bus.fill_vpn_o        = VPN_W'(req_q.vpn);
      bus.fill_pte_o        = PTE_W'(pte_q);
      bus.plru_access_hit_o = 1'b0;
      bus.plru_access_idx_o = '0;
      bus.miss_error_o      = miss_error_q;

      if (hit_accept) begin
         bus.plru_access_hit_o = 1'b1;
         bus.plru_access_idx_o = bus.lookup_hit_idx_i;
      end

      // The freshly written entry becomes most-recently-used.
      if ((state_q == ST_FILL) && !bus.flush_i) begin
         bus.fill_valid_o      = 1'b1;
         bus.plru_access_hit_o = 1'b1;
         bus.plru_access_idx_o = victim_q;
      end
   end

   // ---------------------------------------------------------------- refill context
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         req_q        <= '0;
         pte_q        <= '0;
         victim_q     <= '0;
         miss_error_q <= 1'b0;
      end else begin
         if (miss_accept) begin
            req_q.vpn <= TLB_VPN_W'(bus.lookup_vpn_i);
            victim_q  <= bus.plru_replacement_idx_i;
         end
         if (resp_ok) begin
            pte_q <= resp.pte;
         end
         miss_error_q <= resp_err;
      end
   end

`ifdef TLB_REFILL_PERF_EN
   // ---------------------------------------------------------------- event counters
   logic [31:0] miss_cnt_q;
   logic [31:0] hit_cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         miss_cnt_q <= '0;
         hit_cnt_q  <= '0;
      end else begin
         if (miss_accept) miss_cnt_q <= sat_inc(miss_cnt_q);
         if (hit_accept)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      end
   end

   assign miss_count_o = miss_cnt_q;
   assign hit_count_o  = hit_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl: per-cycle vector table plus a reset-during-walk sequence.
// Latency: inputs applied at falling edge, outputs compared 2 ns later, well away from the rising edge.
// Backpressure: walker ready and response timing are scripted per vector.
// With TLB_REFILL_PERF_EN defined the counter ports are connected but not scored.
module tb_tlb_refill_ctrl;
   import tlb_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   tlb_refill_ctrl_if #(.ENTRIES(8), .VPN_W(27), .PTE_W(64)) bus ();

`ifdef TLB_REFILL_PERF_EN
   logic [31:0] miss_count;
   logic [31:0] hit_count;
`endif

   tlb_refill_ctrl #(.ENTRIES(8), .VPN_W(27), .PTE_W(64)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
`ifdef TLB_REFILL_PERF_EN
      ,
      .miss_count_o (miss_count),
      .hit_count_o  (hit_count)
`endif
   );

   typedef struct {
      logic [95:0]  nm;
      logic         fl, lv, ht;
      logic [2:0]   hi;
      logic [26:0]  vpn;
      logic [2:0]   rp;
      logic         prdy, rv, re;
      logic [63:0]  pte;
      logic         m_phit, m_pvld, m_fvld;
      logic [129:0] exp;
   } vec_t;

   vec_t vq[$];
   int   passed = 0;
   int   total  = 0;

   // {ready, busy, plru_hit, plru_idx, req_valid, req_vpn, fill_valid, fill_idx, fill_vpn, fill_pte, miss_error}
   function automatic logic [129:0] pack(input logic rdy, busy, phit, input logic [2:0] pidx,
                                         input logic pvld, input logic [26:0] pvpn,
                                         input logic fvld, input logic [2:0] fidx,
                                         input logic [26:0] fvpn, input logic [63:0] fpte,
                                         input logic merr);
      return {rdy, busy, phit, pidx, pvld, pvpn, fvld, fidx, fvpn, fpte, merr};
   endfunction

   // Data fields are hidden unless their qualifier is expected high, or full is set.
   function automatic logic [129:0] actual(input logic full, input logic m_phit, m_pvld, m_fvld);
      return pack(bus.lookup_ready_o, bus.busy_o, bus.plru_access_hit_o,
                  (full || m_phit) ? bus.plru_access_idx_o : 3'd0,
                  bus.ptw_req_valid_o,
                  (full || m_pvld) ? bus.ptw_req_vpn_o : 27'd0,
                  bus.fill_valid_o,
                  (full || m_fvld) ? bus.fill_idx_o : 3'd0,
                  (full || m_fvld) ? bus.fill_vpn_o : 27'd0,
                  (full || m_fvld) ? bus.fill_pte_o : 64'd0,
                  bus.miss_error_o);
   endfunction

   task automatic check(input logic [95:0] nm, input logic [129:0] act, input logic [129:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %0s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic fl, lv, ht, input logic [2:0] hi, input logic [26:0] vpn,
                        input logic [2:0] rp, input logic prdy, rv, re, input logic [63:0] pte);
      bus.flush_i                = fl;
      bus.lookup_valid_i         = lv;
      bus.lookup_hit_i           = ht;
      bus.lookup_hit_idx_i       = hi;
      bus.lookup_vpn_i           = vpn;
      bus.plru_replacement_idx_i = rp;
      bus.ptw_req_ready_i        = prdy;
      bus.ptw_resp_valid_i       = rv;
      bus.ptw_resp_error_i       = re;
      bus.ptw_resp_pte_i         = pte;
   endtask

   // inputs: flush lv hit hit_idx vpn repl req_rdy resp_v resp_err pte
   // expect: ready busy plru_hit plru_idx req_v req_vpn fill_v fill_idx fill_vpn fill_pte miss_err
   task automatic add(input logic [95:0] nm,
                      input logic fl, lv, ht, input logic [2:0] hi, input logic [26:0] vpn,
                      input logic [2:0] rp, input logic prdy, rv, re, input logic [63:0] pte,
                      input logic e_rdy, e_busy, e_phit, input logic [2:0] e_pidx,
                      input logic e_pvld, input logic [26:0] e_pvpn,
                      input logic e_fvld, input logic [2:0] e_fidx,
                      input logic [26:0] e_fvpn, input logic [63:0] e_fpte, input logic e_merr);
      vec_t v;
      v.nm = nm; v.fl = fl; v.lv = lv; v.ht = ht; v.hi = hi; v.vpn = vpn; v.rp = rp;
      v.prdy = prdy; v.rv = rv; v.re = re; v.pte = pte;
      v.m_phit = e_phit; v.m_pvld = e_pvld; v.m_fvld = e_fvld;
      v.exp = pack(e_rdy, e_busy, e_phit, e_pidx, e_pvld, e_pvpn, e_fvld, e_fidx, e_fvpn, e_fpte, e_merr);
      vq.push_back(v);
   endtask

   initial begin
      //   name          fl lv ht hi  vpn         rp prdy rv re pte            rdy busy phit pidx pv pvpn        fv fidx fvpn        fpte           merr
      // hit at idx 5, and a hit flag without lookup_valid
      add("hit5",        0, 1, 1, 5, 27'h0,      0, 0, 0, 0, 64'h0,         1, 0, 1, 5, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("hit_nolv",    0, 0, 1, 2, 27'h0,      0, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // miss 0x1234 victim 3, ready immediate, response two cycles later
      add("missB",       0, 1, 0, 0, 27'h1234,   3, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqB",        0, 0, 0, 0, 27'h0,      7, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h1234,   0, 0, 27'h0,      64'h0,     0);
      add("waitB1",      0, 0, 0, 0, 27'h0,      7, 0, 0, 0, 64'hDEAD,      0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("waitB2",      0, 0, 0, 0, 27'h0,      7, 0, 1, 0, 64'hABCD,      0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("fillB",       0, 0, 0, 0, 27'h0,      7, 0, 0, 0, 64'h0,         0, 1, 1, 3, 0, 27'h0,      1, 3, 27'h1234,   64'hABCD,  0);
      add("idleB",       0, 0, 0, 0, 27'h0,      7, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // victim changes 3 -> 6 after the miss; walker holds off ready once
      add("missC",       0, 1, 0, 0, 27'h55,     3, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqC_hold",   0, 0, 0, 0, 27'h0,      3, 0, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h55,     0, 0, 27'h0,      64'h0,     0);
      add("reqC",        0, 0, 0, 0, 27'h0,      3, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h55,     0, 0, 27'h0,      64'h0,     0);
      add("waitC",       0, 0, 0, 0, 27'h0,      6, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("waitC_resp",  0, 0, 0, 0, 27'h0,      6, 0, 1, 0, 64'h77,        0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("fillC",       0, 0, 0, 0, 27'h0,      6, 0, 0, 0, 64'h0,         0, 1, 1, 3, 0, 27'h0,      1, 3, 27'h55,     64'h77,    0);
      // walk fault: one-cycle error pulse after returning to IDLE, no fill
      add("missD",       0, 1, 0, 0, 27'h99,     1, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqD",        0, 0, 0, 0, 27'h0,      1, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h99,     0, 0, 27'h0,      64'h0,     0);
      add("waitD_err",   0, 0, 0, 0, 27'h0,      1, 0, 1, 1, 64'h5,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("errD",        0, 0, 0, 0, 27'h0,      1, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     1);
      add("idleD",       0, 0, 0, 0, 27'h0,      1, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // flush in WAIT, response four cycles later is drained
      add("missE",       0, 1, 0, 0, 27'h42,     2, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqE",        0, 0, 0, 0, 27'h0,      2, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h42,     0, 0, 27'h0,      64'h0,     0);
      add("flushE",      1, 0, 0, 0, 27'h0,      2, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("drainE1",     0, 1, 1, 1, 27'h0,      2, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("drainE2",     0, 0, 0, 0, 27'h0,      2, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("drainE3",     0, 0, 0, 0, 27'h0,      2, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("drainE4",     0, 0, 0, 0, 27'h0,      2, 0, 1, 0, 64'h99,        0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("idleE",       0, 0, 0, 0, 27'h0,      2, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // flush in IDLE blocks hit update and miss acceptance
      add("flushF_hit",  1, 1, 1, 4, 27'h0,      0, 0, 0, 0, 64'h0,         0, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("flushF_miss", 1, 1, 0, 0, 27'h66,     0, 0, 0, 0, 64'h0,         0, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("idleF",       0, 0, 0, 0, 27'h0,      0, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // flush in REQ with ready low aborts
      add("missG",       0, 1, 0, 0, 27'h10,     7, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqG_flush",  1, 0, 0, 0, 27'h0,      7, 0, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h10,     0, 0, 27'h0,      64'h0,     0);
      add("idleG",       0, 0, 0, 0, 27'h0,      7, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // flush in REQ with ready high: handshake completes, drain swallows faulting response
      add("missH",       0, 1, 0, 0, 27'h11,     0, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqH_flush",  1, 0, 0, 0, 27'h0,      0, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h11,     0, 0, 27'h0,      64'h0,     0);
      add("drainH",      0, 0, 0, 0, 27'h0,      0, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("drainH_resp", 0, 0, 0, 0, 27'h0,      0, 0, 1, 1, 64'h1,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("idleH",       0, 0, 0, 0, 27'h0,      0, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // flush in WAIT together with the response: discarded, straight to IDLE
      add("missI",       0, 1, 0, 0, 27'h12,     4, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqI",        0, 0, 0, 0, 27'h0,      4, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h12,     0, 0, 27'h0,      64'h0,     0);
      add("waitI_flush", 1, 0, 0, 0, 27'h0,      4, 0, 1, 0, 64'h88,        0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("idleI",       0, 0, 0, 0, 27'h0,      4, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      // flush in FILL suppresses the write and PLRU update
      add("missJ",       0, 1, 0, 0, 27'h20,     5, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("reqJ",        0, 0, 0, 0, 27'h0,      5, 1, 0, 0, 64'h0,         0, 1, 0, 0, 1, 27'h20,     0, 0, 27'h0,      64'h0,     0);
      add("waitJ",       0, 0, 0, 0, 27'h0,      5, 0, 1, 0, 64'h33,        0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("fillJ_flush", 1, 0, 0, 0, 27'h0,      5, 0, 0, 0, 64'h0,         0, 1, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);
      add("idleJ",       0, 0, 0, 0, 27'h0,      5, 0, 0, 0, 64'h0,         1, 0, 0, 0, 0, 27'h0,      0, 0, 27'h0,      64'h0,     0);

      // reset state: only lookup_ready is high, every data output zero
      drive(0, 0, 0, 3'd0, 27'h0, 3'd0, 0, 0, 0, 64'h0);
      @(negedge clk);
      #2;
      check("reset", actual(1'b1, 1'b0, 1'b0, 1'b0),
            pack(1, 0, 0, 3'd0, 0, 27'h0, 0, 3'd0, 27'h0, 64'h0, 0));
      @(negedge clk);
      rstn = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].fl, vq[i].lv, vq[i].ht, vq[i].hi, vq[i].vpn, vq[i].rp,
               vq[i].prdy, vq[i].rv, vq[i].re, vq[i].pte);
         #2;
         check(vq[i].nm, actual(1'b0, vq[i].m_phit, vq[i].m_pvld, vq[i].m_fvld), vq[i].exp);
      end

      // reset asserted mid-walk clears everything; a late response is ignored
      @(negedge clk);
      drive(0, 1, 0, 3'd0, 27'h3FF, 3'd6, 0, 0, 0, 64'h0);
      @(negedge clk);
      drive(0, 0, 0, 3'd0, 27'h0, 3'd6, 1, 0, 0, 64'h0);
      @(negedge clk);
      drive(0, 0, 0, 3'd0, 27'h0, 3'd6, 0, 0, 0, 64'h0);
      #2;
      check("rst_pre_wait", actual(1'b0, 1'b0, 1'b0, 1'b0),
            pack(0, 1, 0, 3'd0, 0, 27'h0, 0, 3'd0, 27'h0, 64'h0, 0));
      #1 rstn = 1'b0;
      #1;
      check("rst_in_wait", actual(1'b1, 1'b0, 1'b0, 1'b0),
            pack(1, 0, 0, 3'd0, 0, 27'h0, 0, 3'd0, 27'h0, 64'h0, 0));
      @(negedge clk);
      rstn = 1'b1;
      drive(0, 0, 0, 3'd0, 27'h0, 3'd6, 0, 1, 0, 64'hFFFF);
      #2;
      check("rst_late_resp", actual(1'b1, 1'b0, 1'b0, 1'b0),
            pack(1, 0, 0, 3'd0, 0, 27'h0, 0, 3'd0, 27'h0, 64'h0, 0));
      @(negedge clk);
      drive(0, 0, 0, 3'd0, 27'h0, 3'd6, 0, 0, 0, 64'h0);
      #2;
      check("rst_after", actual(1'b1, 1'b0, 1'b0, 1'b0),
            pack(1, 0, 0, 3'd0, 0, 27'h0, 0, 3'd0, 27'h0, 64'h0, 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
